payload_match_collector: RTL and testbench
==========================================

Name: payload_match_collector

Overview:
- Sits directly downstream of the payload engine array.
- Samples the sticky end-state outputs of NUM_ENG engines once per packet payload, after the final byte has settled.
- Reduces them to a result record: hit flag, lowest matching engine index and match count.
- Queues each record in a small FIFO behind a valid/ready handshake, where the rule-report logic picks it up.

Parameters:
- NUM_ENG, 64, number of engine out lines; must be at least 2.
- ID_W, 6, width of the engine index; must satisfy 2**ID_W >= NUM_ENG.
- CNT_W, 7, width of the match popcount; must hold NUM_ENG.
- PKT_ID_W, 16, width of the packet tag.
- FIFO_DEPTH, 4, result FIFO entries; must be a power of 2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- sod  in  1  start of data; the same pulse that clears the engines.
- eod  in  1  end of data; asserted together with en on the last payload byte.
- en  in  1  byte strobe shared with the engines.
- pkt_id  in  PKT_ID_W  packet tag; valid when sod=1.
- eng_match  in  NUM_ENG  engine end-state outputs; bit i is engine i.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer accepts the head.
- res_pkt_id  out  PKT_ID_W  tag of the head record.
- res_hit  out  1  at least one engine matched.
- res_eng_id  out  ID_W  lowest matching engine index; 0 when res_hit=0.
- res_count  out  CNT_W  number of matching engines.
- drop_cnt  out  16  records dropped because the FIFO was full; saturates at 0xFFFF.
- abort_cnt  out  16  packets abandoned by sod before capture; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied.
  - res_valid=0; res_pkt_id, res_hit, res_eng_id and res_count are 0.
  - drop_cnt=0; abort_cnt=0.
- FSM states are IDLE, ACTIVE and CAPTURE.
- IDLE:
  - sod=1 latches pkt_id into cur_id and moves to ACTIVE.
  - eod is ignored.
- ACTIVE:
  - sod=1 re-latches pkt_id and stays in ACTIVE. No record is produced and abort_cnt increments.
  - Otherwise, eod=1 with en=1 moves to CAPTURE.
  - eod with en=0 is ignored.
- CAPTURE (exactly one cycle, T+1 after the last-byte cycle T):
  - eng_match now reflects the final byte, because the engine flops updated at the end of cycle T.
  - The block computes, combinationally from eng_match:
    - hit = OR of all bits.
    - eng_id = index of the lowest set bit.
    - count = popcount.
  - {cur_id, hit, eng_id, count} is pushed at the end of the cycle, then the FSM returns to IDLE.
  - If sod=1 in CAPTURE, the engines clear asynchronously and eng_match is unreliable, so sod takes priority:
    - no push;
    - abort_cnt increments;
    - pkt_id is latched;
    - the FSM goes to ACTIVE.
- Latency: the record is visible on res_* at cycle T+2 when the FIFO was empty.
- FIFO:
  - Registered outputs; show-ahead, so the head record is driven whenever res_valid=1.
  - A pop occurs when res_valid && res_ready.
  - Push while full: if a pop occurs in the same cycle, the push is accepted. Otherwise the record is discarded and drop_cnt increments.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap. Full means MSBs differ and the remaining bits are equal.
  - res_* hold their value while res_valid=1 and res_ready=0.
- en gates only the sod/eod qualification described above; the FIFO and the handshake operate regardless of en.
- Both counters saturate and never wrap.

Test Plan:
- Single match:
  - Stimulus: sod with pkt_id=0x0012; 5 bytes; eng_match bit 55 rises after byte 3; eod on byte 5.
  - Required: res_valid at T+2 with id 0x0012, hit=1, eng_id=55, count=1.
- Multiple matches and no match:
  - Stimulus: packet A with bits 3, 9 and 60 set; then packet B with no bits set.
  - Required: A gives eng_id=3, count=3. B gives hit=0, eng_id=0, count=0, with records in order.
- Backpressure:
  - Stimulus: res_ready=0; 5 packets complete.
  - Required: 4 records are held and drop_cnt=1.
  - Then, with res_ready=1 and a capture landing in the same cycle as a pop while full, the push is accepted and drop_cnt stays 1.
- Aborts:
  - Stimulus: sod again in ACTIVE; and sod in the CAPTURE cycle.
  - Required: no record for either, abort_cnt=2. The following packet reports the newest pkt_id.
- eod gating:
  - Stimulus: eod with en=0, then eod with en=1 two cycles later.
  - Required: capture happens only one cycle after the en=1 eod.
- Asynchronous reset:
  - Stimulus: assert rst_n=0 mid-packet with 2 records queued.
  - Required: res_valid drops immediately and both counters read 0. After release, the FSM is in IDLE and eod is ignored until the next sod.

Source files
------------

// File: rtl/payload_match_collector.sv
// Collects the engine end-state vector once per packet, reduces it to a
// hit / lowest-index / popcount record, and queues it for the rule-report logic.
module payload_match_collector #(
  parameter int unsigned NUM_ENG    = 64,
  parameter int unsigned ID_W       = 6,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned PKT_ID_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sod,
  input  logic                eod,
  input  logic                en,
  input  logic [PKT_ID_W-1:0] pkt_id,
  input  logic [NUM_ENG-1:0]  eng_match,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PKT_ID_W-1:0] res_pkt_id,
  output logic                res_hit,
  output logic [ID_W-1:0]     res_eng_id,
  output logic [CNT_W-1:0]    res_count,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         abort_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [PKT_ID_W-1:0] pkt_id;
    logic                hit;
    logic [ID_W-1:0]     eng_id;
    logic [CNT_W-1:0]    count;
  } rec_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [PKT_ID_W-1:0] cur_id_q;
  logic                push_c, abort_c, latch_c;

  // Packet framing FSM; sod always wins because it also clears the engines.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    abort_c = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (sod) begin
          latch_c = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sod) begin
          latch_c = 1'b1;
          abort_c = 1'b1;
        end else if (eod && en) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sod) begin
          latch_c = 1'b1;
          abort_c = 1'b1;
          state_d = ACTIVE;
        end else begin
          push_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_c) cur_id_q <= pkt_id;
    end
  end

  // Reduction of the settled end-state vector.
  logic             hit_c;
  logic [ID_W-1:0]  eng_id_c;
  logic [CNT_W-1:0] count_c;
  rec_t             rec_c;

  always_comb begin
    hit_c    = |eng_match;
    eng_id_c = '0;
    count_c  = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      if (eng_match[i]) eng_id_c = ID_W'(i);
    end
    for (int i = 0; i < int'(NUM_ENG); i++) begin
      count_c = count_c + CNT_W'(eng_match[i]);
    end
    rec_c = '{pkt_id: cur_id_q, hit: hit_c, eng_id: eng_id_c, count: count_c};
  end

  // Result FIFO with registered show-ahead head.
  rec_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic          full_c, pop_c, wr_en_c, drop_c;
  rec_t          head_d;

  always_comb begin
    full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_c    = res_valid && res_ready;
    wr_en_c  = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;
    wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    // A record written into the slot that becomes the head bypasses the array.
    if (wr_en_c && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) head_d = rec_c;
    else                                                   head_d = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      res_valid  <= 1'b0;
      res_pkt_id <= '0;
      res_hit    <= 1'b0;
      res_eng_id <= '0;
      res_count  <= '0;
    end else begin
      if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= rec_c;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      res_valid  <= (wr_ptr_d != rd_ptr_d);
      res_pkt_id <= head_d.pkt_id;
      res_hit    <= head_d.hit;
      res_eng_id <= head_d.eng_id;
      res_count  <= head_d.count;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (drop_c && (drop_cnt != 16'hFFFF))   drop_cnt  <= drop_cnt + 16'd1;
      if (abort_c && (abort_cnt != 16'hFFFF)) abort_cnt <= abort_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_payload_match_collector.sv
// Bench for payload_match_collector: reduction table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_payload_match_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sod = 1'b0, eod = 1'b0, en = 1'b0, res_ready = 1'b0;
  logic [15:0] pkt_id = '0;
  logic [63:0] eng_match = '0;
  logic        res_valid, res_hit;
  logic [15:0] res_pkt_id, drop_cnt, abort_cnt;
  logic [5:0]  res_eng_id;
  logic [6:0]  res_count;

  always #5 clk = ~clk;

  payload_match_collector dut (
    .clk(clk), .rst_n(rst_n), .sod(sod), .eod(eod), .en(en), .pkt_id(pkt_id),
    .eng_match(eng_match), .res_valid(res_valid), .res_ready(res_ready),
    .res_pkt_id(res_pkt_id), .res_hit(res_hit), .res_eng_id(res_eng_id),
    .res_count(res_count), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        hit;
    logic [5:0]  eid;
    logic [6:0]  cnt;
  } rec_t;

  typedef struct {
    logic [63:0] m;
    logic        hit;
    logic [5:0]  eid;
    logic [6:0]  cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  rec_t        q[$];
  logic [15:0] m_drop, m_abort, m_cur;
  bit          m_open, m_cap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t ref_rec(input logic [15:0] id, input logic [63:0] m);
    rec_t r;
    r.id  = id;
    r.hit = (m != 0);
    r.eid = '0;
    r.cnt = 7'($countones(m));
    for (int i = 0; i < 64; i++) begin
      if (m[i]) begin
        r.eid = 6'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_drop = '0; m_abort = '0; m_cur = '0;
    m_open = 0; m_cap = 0;
  endtask

  // One clock: predict from current inputs, clock, then compare.
  task automatic step();
    bit   pop, do_push, n_open, n_cap, ab;
    rec_t r;
    logic [15:0] n_cur;
    pop = (q.size() != 0) && res_ready;
    do_push = 0; ab = 0;
    n_open = m_open; n_cap = m_cap; n_cur = m_cur;
    r = '0;
    if (m_cap && !sod) begin
      do_push = 1;
      r = ref_rec(m_cur, eng_match);
    end
    if (sod) begin
      ab = m_open || m_cap;
      n_cur = pkt_id; n_open = 1; n_cap = 0;
    end else if (m_cap) begin
      n_cap = 0;
    end else if (m_open && eod && en) begin
      n_open = 0; n_cap = 1;
    end
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(r);
      else if (m_drop != 16'hFFFF) m_drop++;
    end
    if (ab && m_abort != 16'hFFFF) m_abort++;
    m_open = n_open; m_cap = n_cap; m_cur = n_cur;
    check("status", 64'({res_valid, drop_cnt, abort_cnt}),
          64'({(q.size() != 0), m_drop, m_abort}));
    if (q.size() != 0)
      check("head", 64'({res_pkt_id, res_hit, res_eng_id, res_count}), 64'(q[0]));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    sod = 0; eod = 0; en = 0; res_ready = 0; eng_match = '0;
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_open(input logic [15:0] id);
    sod = 1; pkt_id = id; eng_match = '0;
    step();
    sod = 0;
  endtask

  task automatic send_bytes(input int n, input logic [63:0] m, input bit last);
    for (int b = 1; b <= n; b++) begin
      en = 1;
      eod = last && (b == n);
      eng_match = (b > 3) ? m : 64'h0;
      step();
    end
    en = 0; eod = 0; eng_match = m;
  endtask

  vec_t tbl[6];
  int   seen;

  initial begin
    tbl[0] = '{64'h0080_0000_0000_0000, 1'b1, 6'd55, 7'd1};
    tbl[1] = '{64'h1000_0000_0000_0208, 1'b1, 6'd3,  7'd3};
    tbl[2] = '{64'h0000_0000_0000_0000, 1'b0, 6'd0,  7'd0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd0,  7'd64};
    tbl[4] = '{64'h8000_0000_0000_0000, 1'b1, 6'd63, 7'd1};
    tbl[5] = '{64'hF0F0_0000_0000_0000, 1'b1, 6'd52, 7'd8};

    model_reset();
    #12;
    check("reset_valid", 64'(res_valid), 64'd0);
    check("reset_head", 64'({res_pkt_id, res_hit, res_eng_id, res_count}), 64'd0);
    check("reset_cnts", 64'({drop_cnt, abort_cnt}), 64'd0);
    @(negedge clk); rst_n = 1;

    // Single match with latency check
    send_open(16'h0012);
    send_bytes(5, 64'h0080_0000_0000_0000, 1);
    check("lat_t1_valid", 64'(res_valid), 64'd0);
    step();
    check("lat_t2_valid", 64'(res_valid), 64'd1);
    check("single_rec", 64'({res_pkt_id, res_hit, res_eng_id, res_count}),
          64'({16'h0012, 1'b1, 6'd55, 7'd1}));

    // Reduction table, one packet per entry
    do_reset();
    res_ready = 1;
    foreach (tbl[i]) begin
      send_open(16'h0100 + 16'(i));
      send_bytes(4, tbl[i].m, 1);
      step();
      check("tbl_rec", 64'({res_valid, res_pkt_id, res_hit, res_eng_id, res_count}),
            64'({1'b1, 16'h0100 + 16'(i), tbl[i].hit, tbl[i].eid, tbl[i].cnt}));
      step();
    end

    // Backpressure: 5 packets into 4 slots, then push-while-full with pop
    do_reset();
    for (int p = 0; p < 5; p++) begin
      send_open(16'h0200 + 16'(p));
      send_bytes(2, 64'(1) << p, 1);
      step();
    end
    check("bp_drop1", 64'(drop_cnt), 64'd1);
    send_open(16'h0299);
    send_bytes(2, 64'h0000_0000_0000_0400, 1);
    res_ready = 1;
    step();
    check("bp_full_pop_drop", 64'(drop_cnt), 64'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (res_valid) seen++;
      step();
    end
    check("bp_drained", 64'(seen), 64'd4);

    // Aborts: sod in ACTIVE and sod in CAPTURE
    do_reset();
    send_open(16'h00A1);
    send_bytes(2, 64'h0, 0);
    send_open(16'h00A2);
    send_bytes(2, 64'h0000_0000_0000_0001, 1);
    sod = 1; pkt_id = 16'h00A3;
    step();
    sod = 0;
    check("abort_no_rec", 64'(res_valid), 64'd0);
    send_bytes(2, 64'h0000_0000_0000_0020, 1);
    step();
    check("abort_cnt2", 64'(abort_cnt), 64'd2);
    check("abort_newest", 64'({res_valid, res_pkt_id, res_eng_id}), 64'({1'b1, 16'h00A3, 6'd5}));

    // eod gating by en
    do_reset();
    send_open(16'h0033);
    en = 0; eod = 1; eng_match = 64'h4; step();
    eod = 0; step();
    check("gate_no_cap", 64'(res_valid), 64'd0);
    en = 1; eod = 1; step();
    en = 0; eod = 0;
    check("gate_t1", 64'(res_valid), 64'd0);
    step();
    check("gate_t2", 64'({res_valid, res_pkt_id, res_eng_id}), 64'({1'b1, 16'h0033, 6'd2}));

    // Async reset mid-packet with 2 records queued
    do_reset();
    for (int p = 0; p < 2; p++) begin
      send_open(16'h0300 + 16'(p));
      send_bytes(1, 64'h1, 1);
      step();
    end
    send_open(16'h0310);
    send_open(16'h0311);
    send_bytes(2, 64'h0, 0);
    check("pre_rst_state", 64'({res_valid, abort_cnt}), 64'({1'b1, 16'd1}));
    #2 rst_n = 0;
    #1;
    check("async_rst", 64'({res_valid, drop_cnt, abort_cnt}), 64'd0);
    model_reset();
    en = 0; eod = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    en = 1; eod = 1; eng_match = 64'h8;
    for (int k = 0; k < 3; k++) step();
    en = 0; eod = 0;
    check("post_rst_idle", 64'(res_valid), 64'd0);
    send_open(16'h0320);
    send_bytes(1, 64'h8, 1);
    step();
    check("post_rst_rec", 64'({res_valid, res_pkt_id, res_eng_id}), 64'({1'b1, 16'h0320, 6'd3}));

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      sod = ($urandom_range(0, 7) == 0);
      eod = ($urandom_range(0, 3) == 0);
      en = $urandom_range(0, 1) != 0;
      res_ready = ($urandom_range(0, 2) != 0);
      pkt_id = 16'($urandom);
      case ($urandom_range(0, 3))
        0: eng_match = '0;
        1: eng_match = 64'(1) << $urandom_range(0, 63);
        2: eng_match = {$urandom, $urandom} & {$urandom, $urandom};
        default: eng_match = ~(64'(1) << $urandom_range(0, 63));
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
